// File: rtl/sid_arb_pkg.sv
// Shared encodings for the SID register-bus arbiter: clock-source FSM states
// and the write-source select.
package sid_arb_pkg;

  typedef enum logic {
    ST_INT = 1'b0,
    ST_EXT = 1'b1
  } clk_state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CPU  = 2'd1,
    SRC_HOST = 2'd2
  } src_t;

endpackage

// File: rtl/sid_arb_fifo.sv
// Host-write FIFO for the SID arbiter: 2**FIFO_AW entries of DW bits,
// head visible on dout while non-empty, no write-through bypass.
module sid_arb_fifo #(
  parameter int DW      = 13,
  parameter int FIFO_AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               do_push;
  logic               do_pop;

  // count only reaches 2**FIFO_AW when full, so its MSB is the full flag
  assign full    = count[FIFO_AW];
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sid_bus_arb.sv
// SID register-bus arbiter: merges CPU and host-FIFO writes and sources the SID tick
// from PHI2 or an internal divider. Define SID_ARB_SHADOW_EN for the readable shadow RAM.
module sid_bus_arb
  import sid_arb_pkg::*;
#(
  parameter int AW      = 5,
  parameter int FIFO_AW = 3,
  parameter int DIV     = 24,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_clk_en,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  input  logic [AW-1:0] host_raddr,
  output logic [7:0]    host_rdata,
  output logic [AW-1:0] sid_addr,
  output logic [7:0]    sid_wdata,
  output logic          sid_we,
  output logic          sid_clk_en,
  output logic          ext_mode
);

  localparam int DIV_W = $clog2(DIV);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  clk_state_t       state;
  logic [DIV_W-1:0] div_cnt;
  logic [WD_W-1:0]  wdog;

  src_t             src;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW+7:0]    fifo_dout;
  logic             nxt_we;
  logic [AW-1:0]    nxt_addr;
  logic [7:0]       nxt_wdata;

  assign host_ready = ~fifo_full;
  assign fifo_push  = host_valid & host_ready;

  sid_arb_fifo #(
    .DW      (AW + 8),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ({host_addr, host_wdata}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // CPU writes always win; the FIFO head waits until a CPU-free cycle
  always_comb begin
    src = SRC_NONE;
    if (cpu_we)           src = SRC_CPU;
    else if (!fifo_empty) src = SRC_HOST;
  end

  assign fifo_pop  = (src == SRC_HOST);
  assign nxt_we    = (src != SRC_NONE);
  assign nxt_addr  = (src == SRC_CPU) ? cpu_addr  : fifo_dout[AW+7:8];
  assign nxt_wdata = (src == SRC_CPU) ? cpu_wdata : fifo_dout[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sid_we    <= 1'b0;
      sid_addr  <= '0;
      sid_wdata <= '0;
    end else begin
      sid_we <= nxt_we;
      if (nxt_we) begin
        sid_addr  <= nxt_addr;
        sid_wdata <= nxt_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INT;
      div_cnt    <= '0;
      wdog       <= '0;
      sid_clk_en <= 1'b0;
      ext_mode   <= 1'b0;
    end else begin
      sid_clk_en <= 1'b0;
      case (state)
        ST_INT: begin
          if (cpu_clk_en) begin
            state      <= ST_EXT;
            ext_mode   <= 1'b1;
            sid_clk_en <= 1'b1;
            div_cnt    <= '0;
            wdog       <= '0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt    <= '0;
            sid_clk_en <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_EXT: begin
          sid_clk_en <= cpu_clk_en;
          if (cpu_clk_en) begin
            wdog <= '0;
          end else if (wdog == WD_LAST) begin
            // PHI2 gone quiet: restart the internal divider from zero
            state    <= ST_INT;
            ext_mode <= 1'b0;
            wdog     <= '0;
            div_cnt  <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= ST_INT;
      endcase
    end
  end

`ifdef SID_ARB_SHADOW_EN
  logic [7:0] shadow [1 << AW];

  // read samples pre-write contents, so a same-address collision returns old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < (1 << AW); i++) shadow[i] <= '0;
      host_rdata <= '0;
    end else begin
      if (nxt_we) shadow[nxt_addr] <= nxt_wdata;
      host_rdata <= shadow[host_raddr];
    end
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^host_raddr;
  assign host_rdata   = '0;
`endif

endmodule
